uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: the receive FSM state encoding, frame constants
// and the default bit period.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the
// idle-high level so reset never looks like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic sync
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= line;
            sync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-samples each bit, holds one byte for the
// consumer and flags overrun and framing errors.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic       UART_RXD,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e      state, state_next;
    logic             rxd_s;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift;
    logic [1:0]       settle;
    logic             armed;
    logic             half_tick, full_tick;
    logic             byte_done, frame_bad;

    uart_rx_sync u_sync (
        .clk   (CLOCK_50),
        .rst_n (RST_N),
        .line  (UART_RXD),
        .sync  (rxd_s)
    );

    assign half_tick = (baud_cnt == HALF_LAST);
    assign full_tick = (baud_cnt == FULL_LAST);
    assign rx_busy   = (state != IDLE);

    // The synchronizer output is only trustworthy two cycles after reset;
    // a start needs the real line to have been seen high first.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            if (settle != 2'd2)
                settle <= settle + 2'd1;
            if (settle == 2'd2 && rxd_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        byte_done  = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE:      if (armed && !rxd_s) state_next = START;
            START:     if (half_tick) state_next = rxd_s ? IDLE : DATA;
            DATA:      if (full_tick && bit_cnt == LAST_BIT) state_next = STOP;
            STOP: begin
                if (full_tick) begin
                    state_next = rxd_s ? IDLE : WAIT_HIGH;
                    byte_done  = rxd_s;
                    frame_bad  = !rxd_s;
                end
            end
            WAIT_HIGH: if (rxd_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
        end else begin
            case (state)
                START, STOP: baud_cnt <= (state == START ? half_tick : full_tick)
                                         ? '0 : baud_cnt + 1'b1;
                DATA: begin
                    if (full_tick) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 3'd1;
                        shift    <= {rxd_s, shift[7:1]};
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    baud_cnt <= '0;
                    bit_cnt  <= 3'd0;
                end
            endcase
        end
    end

    // Completion with a same-cycle ack counts as consumed-then-refilled.
    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_frame_err <= frame_bad;
            if (byte_done) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
                if (rx_valid)
                    rx_overrun <= !rx_ack;
            end else if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule
